uart_sram_tx_interface: RTL and testbench

Transmit-side counterpart of the UART SRAM receive path: on a start pulse, reads a contiguous block of 16-bit words from SRAM and sends each word over UART_TX_O as two 8N1 bytes, high byte first, with no idle gap between frames. It sits beside the UART receive unit under the top-level FSM. The top level grants it the SRAM address bus only while Busy is high, and drives UART_TX_O from it instead of the constant 1.

---
 rtl/uart_sram_tx_interface_pkg.sv | 31 +++
 rtl/uart_tx_serializer.sv | 100 ++++++++++
 rtl/uart_sram_tx_interface.sv | 150 +++++++++++++++
 tb/tb_uart_sram_tx_interface.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared definitions for the UART SRAM transmit path: FSM states, word layout and baud constant.
package uart_sram_tx_interface_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_115200 = 434;
  localparam int unsigned SRAM_ADDR_W              = 18;
  localparam int unsigned SRAM_DATA_W              = 16;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_FETCH,
    S_TX_WAIT,
    S_TX_CAPTURE,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_FINISH
  } tx_state_type;

  typedef enum logic [1:0] {
    S_SER_IDLE,
    S_SER_START,
    S_SER_DATA,
    S_SER_STOP
  } tx_ser_state_type;

  // One SRAM word as it goes on the wire: hi byte first.
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } tx_word_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 byte serializer; tx_ready_o reasserts on the last stop-bit cycle so frames can abut.
module uart_tx_serializer
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       tx_load_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_ready_o,
  output logic       tx_serial_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_ser_state_type state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_SER_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_SER_IDLE: ;
      S_SER_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = S_SER_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SER_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_SER_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SER_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SER_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_SER_IDLE;
    endcase
    // A load overrides the stop-bit exit so the next start bit follows with no gap.
    if (tx_load_i && ready_q) begin
      state_d = S_SER_START;
      cnt_d   = '0;
      tx_d    = 1'b0;
      shift_d = tx_byte_i;
    end
    ready_d = (state_d == S_SER_IDLE) || ((state_d == S_SER_STOP) && (cnt_d == CNT_LAST));
  end

  assign tx_ready_o  = ready_q;
  assign tx_serial_o = tx_q;

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads a block of SRAM words and streams each as two back-to-back 8N1 frames, high byte first.
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic                   Start,
  input  logic [SRAM_ADDR_W-1:0] Start_address,
  input  logic [SRAM_ADDR_W-1:0] Word_count,
  output logic [SRAM_ADDR_W-1:0] SRAM_address,
  input  logic [SRAM_DATA_W-1:0] SRAM_read_data,
  output logic                   SRAM_we_n,
  output logic                   UART_TX_O,
  output logic                   Busy,
  output logic                   Done
);

  tx_state_type           state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_ADDR_W-1:0] remain_q, remain_d;
  tx_word_t               cur_q, cur_d;
  tx_word_t               nxt_q, nxt_d;
  logic                   nxt_valid_q, nxt_valid_d;
  logic [1:0]             pf_cnt_q, pf_cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tx_load_c;
  logic [7:0]             tx_byte_c;
  logic                   tx_ready;

  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .CLOCK_50_I  (CLOCK_50_I),
    .resetn      (resetn),
    .tx_load_i   (tx_load_c),
    .tx_byte_i   (tx_byte_c),
    .tx_ready_o  (tx_ready),
    .tx_serial_o (UART_TX_O)
  );

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_TX_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      pf_cnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      pf_cnt_q    <= pf_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    nxt_valid_d = nxt_valid_q;
    pf_cnt_d    = pf_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_load_c   = 1'b0;
    tx_byte_c   = cur_q.lo;

    // Prefetch pipeline: address presented at stage 1, data captured at stage 3.
    if (pf_cnt_q != 2'd0) begin
      if (pf_cnt_q == 2'd3) begin
        nxt_d       = tx_word_t'(SRAM_read_data);
        nxt_valid_d = 1'b1;
        remain_d    = remain_q - SRAM_ADDR_W'(1);
        pf_cnt_d    = 2'd0;
      end else begin
        pf_cnt_d = pf_cnt_q + 2'd1;
      end
    end

    case (state_q)
      S_TX_IDLE: begin
        busy_d = Start;
        if (Start) begin
          remain_d = Word_count;
          if (Word_count == '0) begin
            state_d = S_TX_FINISH;
          end else begin
            addr_d  = Start_address;
            state_d = S_TX_FETCH;
          end
        end
      end
      S_TX_FETCH: state_d = S_TX_WAIT;
      S_TX_WAIT:  state_d = S_TX_CAPTURE;
      S_TX_CAPTURE: begin
        cur_d    = tx_word_t'(SRAM_read_data);
        remain_d = remain_q - SRAM_ADDR_W'(1);
        state_d  = S_TX_SEND_HI;
      end
      S_TX_SEND_HI: begin
        tx_byte_c = cur_q.hi;
        if (tx_ready) begin
          tx_load_c = 1'b1;
          state_d   = S_TX_SEND_LO;
          if (remain_q != '0) begin
            addr_d   = addr_q + SRAM_ADDR_W'(1);
            pf_cnt_d = 2'd1;
          end
        end
      end
      S_TX_SEND_LO: begin
        tx_byte_c = cur_q.lo;
        if (tx_ready) begin
          tx_load_c = 1'b1;
          if (nxt_valid_q) begin
            cur_d       = nxt_q;
            nxt_valid_d = 1'b0;
            state_d     = S_TX_SEND_HI;
          end else begin
            state_d = S_TX_FINISH;
          end
        end
      end
      S_TX_FINISH: begin
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = S_TX_IDLE;
        end
      end
      default: state_d = S_TX_IDLE;
    endcase
  end

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Randomized scoreboard bench: stimulus queues expected frames/events, a negedge monitor decodes and compares.
module tb_uart_sram_tx_interface;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  uart_sram_tx_interface #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50_I     (CLOCK_50_I),
    .resetn         (resetn),
    .Start          (Start),
    .Start_address  (Start_address),
    .Word_count     (Word_count),
    .SRAM_address   (SRAM_address),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_we_n      (SRAM_we_n),
    .UART_TX_O      (UART_TX_O),
    .Busy           (Busy),
    .Done           (Done)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  int cyc = 0;
  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  // SRAM with two-cycle read latency.
  logic [15:0] mem [logic [17:0]];
  logic [17:0] sram_a1 = '0;
  always @(posedge CLOCK_50_I) begin
    sram_a1        <= SRAM_address;
    SRAM_read_data <= mem.exists(sram_a1) ? mem[sram_a1] : 16'h0000;
  end

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t      exp_frames[$];
  int          exp_done[$];
  int          exp_rise[$];
  int          exp_fall[$];
  logic [17:0] exp_addr[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected, value %0h (cycle %0d)", name, act, cyc);
  endtask

  task automatic flush_all();
    exp_frames.delete();
    exp_done.delete();
    exp_rise.delete();
    exp_fall.delete();
    exp_addr.delete();
  endtask

  // Monitor: UART decode, Done, Busy edges and SRAM address trace.
  int          rx_pos = -1;
  int          rx_start = 0;
  logic [9:0]  rx_bits = '0;
  logic        prev_busy = 1'b0;
  logic [17:0] prev_addr = '0;
  frame_t      f;

  always @(negedge CLOCK_50_I) begin
    if (!resetn) begin
      rx_pos    = -1;
      prev_busy = 1'b0;
      prev_addr = SRAM_address;
    end else begin
      if (Busy && !prev_busy) begin
        if (exp_rise.size() == 0) fail_event("busy_rise", 32'(cyc));
        else check("busy_rise_cycle", 32'(cyc), 32'(exp_rise.pop_front()));
        if (exp_addr.size() != 0) check("sram_addr_first", 32'(SRAM_address), 32'(exp_addr.pop_front()));
      end else if (Busy && SRAM_address != prev_addr) begin
        if (exp_addr.size() == 0) fail_event("sram_addr_change", 32'(SRAM_address));
        else check("sram_addr_next", 32'(SRAM_address), 32'(exp_addr.pop_front()));
      end
      if (!Busy && prev_busy) begin
        if (exp_fall.size() == 0) fail_event("busy_fall", 32'(cyc));
        else check("busy_fall_cycle", 32'(cyc), 32'(exp_fall.pop_front()));
        if (exp_addr.size() != 0) begin
          fail_event("sram_addr_missing", 32'(exp_addr.size()));
          exp_addr.delete();
        end
      end
      prev_busy = Busy;
      prev_addr = SRAM_address;

      if (Done) begin
        if (exp_done.size() == 0) fail_event("done_pulse", 32'(cyc));
        else check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
      end

      if (rx_pos < 0) begin
        if (UART_TX_O == 1'b0) begin
          rx_pos   = 0;
          rx_start = cyc;
          rx_bits  = '0;
        end
      end else begin
        rx_pos++;
      end
      if (rx_pos >= 0) begin
        if (rx_pos % CPB == CPB / 2) rx_bits[rx_pos / CPB] = UART_TX_O;
        if (rx_pos == FRAME - 1) begin
          rx_pos = -1;
          if (exp_frames.size() == 0) begin
            fail_event("uart_frame", 32'(rx_bits));
          end else begin
            f = exp_frames.pop_front();
            check("frame_data", 32'(rx_bits[8:1]), 32'(f.data));
            check("frame_start_cycle", 32'(rx_start), 32'(f.start));
            check("frame_start_stop_bits", 32'({rx_bits[9], rx_bits[0]}), 32'(2'b10));
          end
        end
      end
    end
  end

  // Reference model: queue what a transfer must produce, then pulse Start.
  task automatic issue(input logic [17:0] a, input logic [17:0] n);
    int          s;
    int          nw;
    logic [17:0] ad;
    logic [15:0] w;
    @(negedge CLOCK_50_I);
    Start         = 1'b1;
    Start_address = a;
    Word_count    = n;
    s             = cyc;
    nw            = int'(n);
    exp_rise.push_back(s + 1);
    if (nw == 0) begin
      exp_done.push_back(s + 2);
      exp_fall.push_back(s + 3);
    end else begin
      for (int i = 0; i < nw; i++) begin
        ad = a + 18'(i);
        w  = mem.exists(ad) ? mem[ad] : 16'h0000;
        exp_addr.push_back(ad);
        exp_frames.push_back('{w[15:8], s + 5 + (2 * i) * FRAME});
        exp_frames.push_back('{w[7:0], s + 5 + (2 * i + 1) * FRAME});
      end
      exp_done.push_back(s + 5 + 20 * nw * CPB);
      exp_fall.push_back(s + 6 + 20 * nw * CPB);
    end
    @(negedge CLOCK_50_I);
    Start = 1'b0;
  endtask

  task automatic fill(input logic [17:0] a, input int n);
    for (int i = 0; i < n; i++) mem[a + 18'(i)] = 16'($urandom);
  endtask

  task automatic wait_drain(input int limit);
    int t;
    t = 0;
    while ((exp_frames.size() != 0 || exp_done.size() != 0 ||
            exp_rise.size() != 0 || exp_fall.size() != 0) && t < limit) begin
      @(negedge CLOCK_50_I);
      t++;
    end
    if (t >= limit) begin
      fail_event("drain_timeout", 32'(t));
      flush_all();
    end
    repeat (3) @(negedge CLOCK_50_I);
  endtask

  initial begin
    repeat (50000) @(posedge CLOCK_50_I);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int lows;

  initial begin
    resetn        = 1'b0;
    Start         = 1'b0;
    Start_address = '0;
    Word_count    = '0;
    repeat (3) @(negedge CLOCK_50_I);
    check("rst_sram_addr", 32'(SRAM_address), 32'h0);
    check("rst_we_n", 32'(SRAM_we_n), 32'h1);
    check("rst_tx", 32'(UART_TX_O), 32'h1);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);

    mem[18'h00010] = 16'hABCD;
    issue(18'h00010, 18'd1);
    wait_drain(2000);

    mem[18'h00100] = 16'h1234;
    mem[18'h00101] = 16'h5678;
    mem[18'h00102] = 16'h9ABC;
    issue(18'h00100, 18'd3);
    wait_drain(2000);

    fill(18'h3FFFF, 1);
    fill(18'h00000, 1);
    issue(18'h3FFFF, 18'd2);
    wait_drain(2000);

    issue(18'h00555, 18'd0);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLOCK_50_I);
      if (UART_TX_O == 1'b0) lows++;
    end
    check("wc0_tx_low_cycles", 32'(lows), 32'h0);
    check("wc0_sram_addr", 32'(SRAM_address), 32'h00000);
    wait_drain(2000);

    fill(18'h00040, 2);
    issue(18'h00040, 18'd2);
    repeat (30) @(negedge CLOCK_50_I);
    Start         = 1'b1;
    Start_address = 18'h00080;
    Word_count    = 18'd5;
    @(negedge CLOCK_50_I);
    Start = 1'b0;
    wait_drain(2000);

    fill(18'h00200, 2);
    issue(18'h00200, 18'd2);
    repeat (54) @(negedge CLOCK_50_I);
    resetn = 1'b0;
    #1;
    check("midrst_tx", 32'(UART_TX_O), 32'h1);
    check("midrst_busy", 32'(Busy), 32'h0);
    flush_all();
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    repeat (FRAME) @(negedge CLOCK_50_I);
    fill(18'h00300, 2);
    issue(18'h00300, 18'd2);
    wait_drain(2000);

    for (int k = 0; k < 5; k++) begin
      logic [17:0] a;
      int          n;
      a = 18'($urandom);
      n = $urandom_range(0, 3);
      fill(a, n);
      issue(a, 18'(n));
      wait_drain(2000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
